// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Definitions shared by the instruction-fetch stage: the datapath width, the
// PC reset value, the bubble instruction and the fetch FSM state encoding.
// -----------------------------------------------------------------------------
package if_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET  = 32'h0000_0000;
  // addi x0,x0,0: the bubble placed in IF/ID whenever nothing real is fetched
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Fetch FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HALT = 2'd2;

endpackage

// File: rtl/if_stage_pc.sv
// -----------------------------------------------------------------------------
// pc_register
// Program counter with three update modes: redirect (highest priority, loads a
// word-aligned target), hold, or advance by 4 (wrapping modulo 2^XLEN).
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset, PC <= PC_RESET
//   hold      in   keep the current PC
//   redirect  in   load target with its low two bits cleared
//   target    in   redirect address
//   pc        out  current PC
// -----------------------------------------------------------------------------
module pc_register
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = target & ALIGN_MASK;
    end else if (!hold) begin
      // Natural wrap of the adder gives 0xFFFFFFFC -> 0x00000000
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: IDLE/RUN/HALT fetch FSM, PC (pc_register) and the
// IF/ID pipeline latch. Flush redirects the PC and squashes IF/ID (priority
// over stall); a fetched zero word halts the stage without entering IF/ID.
//
// Ports:
//   Clk_in, Rst_n_in             clock / asynchronous active-low reset
//   Start_in                     level, leaves IDLE
//   Stall_in                     hold PC and IF/ID
//   Flush_in, BranchTarget_in    redirect PC and squash IF/ID
//   InstrMemData_in              combinational memory data for InstrMemAddr_out
//   InstrMemAddr_out             current PC
//   IFID_PC_out/_Instruction_out/_Valid_out   IF/ID contents
//   Halted_out                   state is HALT
//   FetchCount_out               (only with IF_STAGE_FETCH_CNT_EN defined)
//                                number of valid instructions latched
// -----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
(
  input  logic            Clk_in,
  input  logic            Rst_n_in,
  input  logic            Start_in,
  input  logic            Stall_in,
  input  logic            Flush_in,
  input  logic [XLEN-1:0] BranchTarget_in,
  input  logic [XLEN-1:0] InstrMemData_in,
  output logic [XLEN-1:0] InstrMemAddr_out,
  output logic [XLEN-1:0] IFID_PC_out,
  output logic [XLEN-1:0] IFID_Instruction_out,
  output logic            IFID_Valid_out,
  output logic            Halted_out
`ifdef IF_STAGE_FETCH_CNT_EN
  ,
  output logic [XLEN-1:0] FetchCount_out
`endif
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            pc_hold;
  logic            pc_redirect;
  logic [XLEN-1:0] pc;

  pc_register u_pc (
    .clk      (Clk_in),
    .rst_n    (Rst_n_in),
    .hold     (pc_hold),
    .redirect (pc_redirect),
    .target   (BranchTarget_in),
    .pc       (pc)
  );

  always_comb begin
    state_d      = state_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    pc_hold      = 1'b1;
    pc_redirect  = 1'b0;

    if (state_q == ST_IDLE) begin
      // Flush is deliberately not looked at here
      ifid_pc_d    = PC_RESET;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      if (Start_in) begin
        state_d = ST_RUN;
      end
    end else if (Flush_in) begin
      // Also the only way out of HALT: the zero word may have been wrong-path
      pc_redirect  = 1'b1;
      ifid_pc_d    = PC_RESET;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      state_d      = ST_RUN;
    end else if (Stall_in) begin
      // Everything holds
    end else if (state_q == ST_RUN && InstrMemData_in != '0) begin
      pc_hold      = 1'b0;
      ifid_pc_d    = pc;
      ifid_instr_d = InstrMemData_in;
      ifid_valid_d = 1'b1;
    end else begin
      // Zero word fetched in RUN, or sitting in HALT: bubble and keep PC
      ifid_pc_d    = PC_RESET;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      state_d      = ST_HALT;
    end
  end

  always_ff @(posedge Clk_in or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      state_q      <= ST_IDLE;
      ifid_pc_q    <= PC_RESET;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef IF_STAGE_FETCH_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic            fetch_fire;

  // A real instruction enters IF/ID exactly when the PC advances
  assign fetch_fire = !pc_hold;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (fetch_fire) begin
      fetch_cnt_d = fetch_cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge Clk_in or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      fetch_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign FetchCount_out = fetch_cnt_q;
`endif

  assign InstrMemAddr_out     = pc;
  assign IFID_PC_out          = ifid_pc_q;
  assign IFID_Instruction_out = ifid_instr_q;
  assign IFID_Valid_out       = ifid_valid_q;
  assign Halted_out           = (state_q == ST_HALT);

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed, table-driven bench for if_stage plus hand-written sequences for
// IDLE flush, reset mid-stall and asynchronous reset between edges.
// -----------------------------------------------------------------------------
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        flush;
  logic [31:0] target;
  logic [31:0] mem;
  logic [31:0] addr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        halted;
`ifdef IF_STAGE_FETCH_CNT_EN
  logic [31:0] fcnt;
`endif

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .Clk_in               (clk),
    .Rst_n_in             (rst_n),
    .Start_in             (start),
    .Stall_in             (stall),
    .Flush_in             (flush),
    .BranchTarget_in      (target),
    .InstrMemData_in      (mem),
    .InstrMemAddr_out     (addr),
    .IFID_PC_out          (ifid_pc),
    .IFID_Instruction_out (ifid_instr),
    .IFID_Valid_out       (ifid_valid),
    .Halted_out           (halted)
`ifdef IF_STAGE_FETCH_CNT_EN
    ,
    .FetchCount_out       (fcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stall;
    logic        flush;
    logic [31:0] target;
    logic [31:0] mem;
    logic [31:0] e_pc;
    logic [31:0] e_ifid_pc;
    logic [31:0] e_ifid_instr;
    logic        e_valid;
    logic        e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  function automatic vec_t mk(logic st, logic sl, logic fl, logic [31:0] tg,
                              logic [31:0] md, logic [31:0] pc, logic [31:0] ipc,
                              logic [31:0] ins, logic v, logic h, logic [31:0] c);
    vec_t r;
    r.start = st; r.stall = sl; r.flush = fl; r.target = tg; r.mem = md;
    r.e_pc = pc; r.e_ifid_pc = ipc; r.e_ifid_instr = ins;
    r.e_valid = v; r.e_halt = h; r.e_cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc,
                           input logic [31:0] e_ipc, input logic [31:0] e_ins,
                           input logic e_v, input logic e_h, input logic [31:0] e_c);
    chk({tag, " pc"},        addr,                e_pc);
    chk({tag, " ifid_pc"},   ifid_pc,             e_ipc);
    chk({tag, " ifid_inst"}, ifid_instr,          e_ins);
    chk({tag, " valid"},     {31'd0, ifid_valid}, {31'd0, e_v});
    chk({tag, " halted"},    {31'd0, halted},     {31'd0, e_h});
`ifdef IF_STAGE_FETCH_CNT_EN
    chk({tag, " fcnt"},      fcnt,                e_c);
`else
    if (e_c == 32'hFFFF_FFFF) $display("note: unexpected count sentinel");
`endif
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later
  task automatic step(input logic st, input logic sl, input logic fl,
                      input logic [31:0] tg, input logic [31:0] md);
    start = st; stall = sl; flush = fl; target = tg; mem = md;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    // start stall flush target mem | pc ifid_pc ifid_instr valid halt cnt
    vecs[0]  = mk(1, 0, 0, 32'h0,        32'h00500093, 32'h0,        32'h0,        NOP,          0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 32'h0,        32'h00500093, 32'h4,        32'h0,        32'h00500093, 1, 0, 1);
    vecs[2]  = mk(0, 0, 0, 32'h0,        32'h00A00113, 32'h8,        32'h4,        32'h00A00113, 1, 0, 2);
    vecs[3]  = mk(0, 1, 0, 32'h0,        32'h11111111, 32'h8,        32'h4,        32'h00A00113, 1, 0, 2);
    vecs[4]  = mk(0, 1, 0, 32'h0,        32'h11111111, 32'h8,        32'h4,        32'h00A00113, 1, 0, 2);
    vecs[5]  = mk(0, 0, 0, 32'h0,        32'h00300193, 32'hC,        32'h8,        32'h00300193, 1, 0, 3);
    vecs[6]  = mk(0, 0, 0, 32'h0,        32'h00400213, 32'h10,       32'hC,        32'h00400213, 1, 0, 4);
    vecs[7]  = mk(0, 0, 0, 32'h0,        32'h00000000, 32'h10,       32'h0,        NOP,          0, 1, 4);
    vecs[8]  = mk(0, 0, 0, 32'h0,        32'h00000000, 32'h10,       32'h0,        NOP,          0, 1, 4);
    vecs[9]  = mk(0, 1, 0, 32'h0,        32'h00000000, 32'h10,       32'h0,        NOP,          0, 1, 4);
    vecs[10] = mk(0, 0, 1, 32'h20,       32'h00000000, 32'h20,       32'h0,        NOP,          0, 0, 4);
    vecs[11] = mk(0, 0, 0, 32'h0,        32'h00100013, 32'h24,       32'h20,       32'h00100013, 1, 0, 5);
    vecs[12] = mk(0, 1, 1, 32'h40,       32'h22222222, 32'h40,       32'h0,        NOP,          0, 0, 5);
    vecs[13] = mk(0, 0, 1, 32'hFFFFFFFF, 32'h33333333, 32'hFFFFFFFC, 32'h0,        NOP,          0, 0, 5);
    vecs[14] = mk(0, 0, 0, 32'h0,        32'h00700393, 32'h0,        32'hFFFFFFFC, 32'h00700393, 1, 0, 6);
    vecs[15] = mk(0, 0, 0, 32'h0,        32'h00800413, 32'h4,        32'h0,        32'h00800413, 1, 0, 7);

    rst_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
    target = '0; mem = '0;
    #7;
    check_all("reset", 32'h0, 32'h0, NOP, 0, 0, 0);
    #5;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].start, vecs[i].stall, vecs[i].flush, vecs[i].target, vecs[i].mem);
      check_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ifid_pc,
                vecs[i].e_ifid_instr, vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_cnt);
    end

    // Asynchronous reset mid-RUN, sampled before the next edge
    #1;
    rst_n = 1'b0;
    #1;
    check_all("rstA", 32'h0, 32'h0, NOP, 0, 0, 0);
    rst_n = 1'b1;

    // Flush in IDLE is ignored; without Start the stage stays idle
    step(0, 0, 1, 32'h80, 32'h00500093);
    check_all("idle_flush", 32'h0, 32'h0, NOP, 0, 0, 0);
    step(0, 0, 0, 32'h0, 32'h00500093);
    check_all("idle_hold", 32'h0, 32'h0, NOP, 0, 0, 0);
    step(1, 0, 0, 32'h0, 32'h00500093);
    check_all("start2", 32'h0, 32'h0, NOP, 0, 0, 0);
    step(0, 0, 0, 32'h0, 32'h00500093);
    check_all("fetch2", 32'h4, 32'h0, 32'h00500093, 1, 0, 1);
    step(0, 1, 0, 32'h0, 32'h00A00113);
    check_all("stall2", 32'h4, 32'h0, 32'h00500093, 1, 0, 1);

    // Reset mid-stall, asserted between edges
    #3;
    rst_n = 1'b0;
    #1;
    check_all("rstB", 32'h0, 32'h0, NOP, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 32'h0, 32'h00500093);
    check_all("post_rst_idle", 32'h0, 32'h0, NOP, 0, 0, 0);
    step(1, 0, 0, 32'h0, 32'h00500093);
    check_all("post_rst_start", 32'h0, 32'h0, NOP, 0, 0, 0);
    step(0, 0, 0, 32'h0, 32'h00500093);
    check_all("post_rst_fetch", 32'h4, 32'h0, 32'h00500093, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide Clk_in  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide Rst_n_in  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide Start_in  input  1  level; leaves IDLE and begins fetch.
REQ-004 SHALL provide Stall_in  input  1  load-use hazard; hold PC and IF/ID contents.
REQ-005 SHALL provide Flush_in  input  1  branch taken in ID; redirect PC, squash IF/ID.
REQ-006 SHALL provide BranchTarget_in  input  32  redirect address, sampled when Flush_in=1.
REQ-007 SHALL provide InstrMemData_in  input  32  combinational instruction-memory read data for InstrMemAddr_out.
REQ-008 SHALL provide InstrMemAddr_out  output  32  current PC, driven directly from the PC register.
REQ-009 SHALL provide IFID_PC_out  output  32  PC of the instruction held in IF/ID.
REQ-010 SHALL provide IFID_Instruction_out  output  32  instruction word to the decode/control stage.
REQ-011 SHALL provide IFID_Valid_out  output  1  IF/ID holds a real fetched instruction, not a bubble.
REQ-012 SHALL provide Halted_out  output  1  state is HALT.

Function
REQ-013 SHALL implement states IDLE, RUN and HALT.
REQ-014 IDLE: PC held at 0; IF/ID loaded with bubble; IDLE->RUN on the edge where Start_in=1.
REQ-015 RUN: each edge with Stall_in=0 and Flush_in=0 latches IF/ID <= {PC, InstrMemData_in, valid=1}, PC <= PC+4.
REQ-016 PC+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000) with no other effect.
REQ-017 Bubble SHALL be instruction 0x00000013 (addi x0,x0,0), PC field 0, valid=0.
REQ-018 Stall_in=1 and Flush_in=0: PC, IF/ID and state unchanged.
REQ-019 Flush_in=1 (any state except IDLE): PC <= BranchTarget_in, IF/ID <= bubble, state <= RUN; Flush_in SHALL take priority over Stall_in.
REQ-020 Flush_in in IDLE SHALL be ignored.
REQ-021 RUN->HALT when InstrMemData_in==0x00000000 would be latched (no stall, no flush); the zero word SHALL NOT enter IF/ID; a bubble is loaded instead and PC is held.
REQ-022 HALT: PC held, bubble loaded each edge, Halted_out=1; only Flush_in exits HALT (to RUN, because the zero word may be a wrong-path fetch).
REQ-023 Start_in deassertion after IDLE SHALL have no effect.
REQ-024 BranchTarget_in low two bits SHALL be forced to 0 when loaded into PC.

Reset
REQ-025 Rst_n_in=0 SHALL immediately force state=IDLE, PC=0, IF/ID=bubble (IFID_PC_out=0, IFID_Instruction_out=0x00000013, IFID_Valid_out=0), Halted_out=0.
REQ-026 Reset asserted mid-RUN or mid-stall SHALL discard all in-flight state; deassertion SHALL resume from IDLE.

Configuration
REQ-027 Macro IF_STAGE_FETCH_CNT_EN defined: add output FetchCount_out (32) counting edges where a valid instruction is latched into IF/ID; reset to 0; wraps at 2^32; unchanged during stall, flush, bubble or HALT.
REQ-028 Macro undefined: FetchCount_out port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold the state enumeration, NOP_INSTR constant (0x00000013), PC reset value (0) and XLEN (32).
REQ-030 PC register with load/hold/redirect logic SHALL be a sub-module named pc_register; IF/ID latch and FSM remain in if_stage.

Verification
REQ-031 Reset, Start_in=1, memory words 0x00500093, 0x00A00113 at 0, 4 -> IF/ID shows PC 0 then 4, valid=1; InstrMemAddr_out 4 then 8.
REQ-032 Stall_in=1 for 2 cycles at PC=8 -> PC stays 8, IF/ID unchanged, FetchCount_out (if enabled) unchanged.
REQ-033 Flush_in=1 and Stall_in=1 together, BranchTarget_in=0x40 -> next cycle PC=0x40, IF/ID=bubble, valid=0.
REQ-034 Word 0x00000000 at PC 0x10 -> HALT, Halted_out=1, PC stays 0x10, bubbles only; then Flush_in with target 0x20 -> RUN, PC=0x20.
REQ-035 PC forced to 0xFFFFFFFC via flush, one normal cycle -> PC=0x00000000, IF/ID PC=0xFFFFFFFC.
REQ-036 Rst_n_in pulsed low mid-RUN asynchronously (between edges) -> outputs at reset values before the next edge; Start_in required to refetch from 0.
